// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Accepts one byte per grant, sequences a single frame on the tx block and watches for a stalled frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int CNT_W          = 16
) (
   input  logic                       sys_clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_send,
   output logic [7:0]                 tx_data,
   input  logic                       tx_active,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       err_timeout
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int SW  = IDW + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2,
      COOLDOWN  = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [IDW-1:0]     last_reg, last_next;
   logic [CNT_W-1:0]   wdog_reg, wdog_next;
   logic [NUM_REQ-1:0] ready_reg, ready_next;
   logic               send_reg, send_next;
   logic [7:0]         data_reg, data_next;
   logic [IDW-1:0]     id_reg, id_next;
   logic               busy_reg, busy_next;
   logic               err_reg, err_next;

   logic [7:0]         req_byte   [NUM_REQ];
   logic [SW-1:0]      cand_sum   [NUM_REQ];
   logic [IDW-1:0]     cand_idx   [NUM_REQ];
   logic [NUM_REQ-1:0] cand_valid;
   logic               pick_found;
   logic [IDW-1:0]     pick_idx;
   logic               wdog_expired;

   // Candidate slot gi holds requester (last+1+gi) mod NUM_REQ, so slot 0 has top priority.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         assign req_byte[gi]   = req_data[8*gi +: 8];
         assign cand_sum[gi]   = {1'b0, last_reg} + SW'(gi + 1);
         assign cand_idx[gi]   = (cand_sum[gi] >= SW'(NUM_REQ)) ?
                                 IDW'(cand_sum[gi] - SW'(NUM_REQ)) : IDW'(cand_sum[gi]);
         assign cand_valid[gi] = req_valid[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx[k];
         end
      end
   end

   assign wdog_expired = (wdog_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      wdog_next  = wdog_reg;
      ready_next = '0;
      data_next  = data_reg;
      id_next    = id_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next = SEND;
               data_next  = req_byte[pick_idx];
               id_next    = pick_idx;
               last_next  = pick_idx;
               ready_next = NUM_REQ'(1) << pick_idx;
               wdog_next  = '0;
            end
         end
         SEND: begin
            wdog_next = wdog_reg + CNT_W'(1);
            // A done seen here means the frame was shorter than our sampling window.
            if (tx_done) begin
               state_next = COOLDOWN;
            end else if (wdog_expired) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else if (tx_active) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            wdog_next = wdog_reg + CNT_W'(1);
            if (tx_done) begin
               state_next = COOLDOWN;
            end else if (wdog_expired) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end
         end
         COOLDOWN: begin
            // Wait out a level-held done so it cannot terminate the next frame.
            if (!tx_done && !tx_active) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign send_next = (state_next == SEND);
   assign busy_next = (state_next != IDLE);

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         last_reg  <= IDW'(NUM_REQ - 1);
         wdog_reg  <= '0;
         ready_reg <= '0;
         send_reg  <= 1'b0;
         data_reg  <= '0;
         id_reg    <= '0;
         busy_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         wdog_reg  <= wdog_next;
         ready_reg <= ready_next;
         send_reg  <= send_next;
         data_reg  <= data_next;
         id_reg    <= id_next;
         busy_reg  <= busy_next;
         err_reg   <= err_next;
      end
   end

   assign req_ready   = ready_reg;
   assign tx_send     = send_reg;
   assign tx_data     = data_reg;
   assign grant_id    = id_reg;
   assign busy        = busy_reg;
   assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a scripted tx model plus a frame-timeline reference
// model predicts grants, handshake pulses and per-cycle outputs.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 50;
   localparam int IDW     = 2;

   logic                   sys_clk = 1'b0;
   logic                   reset   = 1'b1;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [8*NUM_REQ-1:0]   req_data  = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   tx_send;
   logic [7:0]             tx_data;
   logic                   tx_active = 1'b0;
   logic                   tx_done   = 1'b0;
   logic [IDW-1:0]         grant_id;
   logic                   busy;
   logic                   err_timeout;

   uart_tx_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (16)
   ) dut (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_send     (tx_send),
      .tx_data     (tx_data),
      .tx_active   (tx_active),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a frame is described by its grant edge and the tx timeline.
   int          t = 0;
   bit          f_on = 1'b0;
   bit          f_never = 1'b0;
   int          f_g = 0, f_a = 0, f_d = 0, f_h = 0, f_ovl = 0;
   int          m_last = NUM_REQ - 1;
   int          m_id = 0;
   logic [7:0]  m_data = 8'h00;
   bit          m_err = 1'b0;

   bit          cfg_rand = 1'b0;
   bit          cfg_never = 1'b0;
   int          cfg_a = 3, cfg_d = 13, cfg_h = 1;
   int          req_mode = 0;   // 0: drop after grant, 1: random, 2: continuous
   logic [NUM_REQ-1:0] cur_valid = '0;
   logic [7:0]  cur_byte [NUM_REQ];

   function automatic int frame_end();
      return f_never ? f_g + TIMEOUT : f_g + f_d + f_h;
   endfunction

   task automatic drive_inputs();
      int k;
      req_valid = cur_valid;
      for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = cur_byte[i];
      k = t + 1 - f_g;
      if (f_on && !f_never) begin
         tx_active = (k >= f_a) && (k <= f_d - 1 + f_ovl);
         tx_done   = (k >= f_d) && (k <= f_d + f_h - 1);
      end else begin
         tx_active = 1'b0;
         tx_done   = 1'b0;
      end
   endtask

   task automatic run_cycles(input int n);
      bit                 granted;
      int                 gid, idx;
      logic [NUM_REQ-1:0] exp_ready;
      bit                 exp_busy, exp_send;
      for (int c = 0; c < n; c++) begin
         @(posedge sys_clk);
         #1;
         t++;
         granted = 1'b0;
         gid     = 0;
         if ((!f_on || t > frame_end()) && (cur_valid != '0)) begin
            for (int j = 1; j <= NUM_REQ; j++) begin
               idx = (m_last + j) % NUM_REQ;
               if (!granted && cur_valid[idx]) begin
                  granted = 1'b1;
                  gid     = idx;
               end
            end
            m_last  = gid;
            m_id    = gid;
            m_data  = cur_byte[gid];
            f_on    = 1'b1;
            f_g     = t;
            f_never = cfg_never;
            if (cfg_rand) begin
               f_a   = int'($urandom_range(1, 4));
               f_d   = f_a + int'($urandom_range(0, 12));
               f_h   = int'($urandom_range(1, 6));
               f_ovl = int'($urandom_range(0, 1));
            end else begin
               f_a   = cfg_a;
               f_d   = cfg_d;
               f_h   = cfg_h;
               f_ovl = 0;
            end
            $display("t=%0d grant id=%0d data=%02h a=%0d d=%0d h=%0d never=%0d",
                     t, gid, m_data, f_a, f_d, f_h, f_never);
         end
         if (f_on && f_never && t == f_g + TIMEOUT) begin
            m_err = 1'b1;
            $display("t=%0d watchdog abort of id=%0d", t, m_id);
         end
         exp_ready = granted ? (NUM_REQ'(1) << gid) : '0;
         exp_busy  = f_on && (t < frame_end());
         exp_send  = f_on && (t < f_g + (f_never ? TIMEOUT : f_a));
         check_value("req_ready",   32'(req_ready),   32'(exp_ready));
         check_value("busy",        32'(busy),        32'(exp_busy));
         check_value("tx_send",     32'(tx_send),     32'(exp_send));
         check_value("tx_data",     32'(tx_data),     32'(m_data));
         check_value("grant_id",    32'(grant_id),    32'(m_id));
         check_value("err_timeout", 32'(err_timeout), 32'(m_err));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (granted && i == gid) begin
               if (req_mode == 1) begin
                  cur_valid[i] = ($urandom_range(0, 1) == 1);
                  cur_byte[i]  = 8'($urandom);
               end else if (req_mode == 0) begin
                  cur_valid[i] = 1'b0;
               end
            end else if (req_mode == 1 && !cur_valid[i]) begin
               cur_byte[i]  = 8'($urandom);
               cur_valid[i] = ($urandom_range(0, 2) == 0);
            end
         end
         drive_inputs();
      end
   endtask

   task automatic set_fixed(input int a, input int d, input int h);
      cfg_rand  = 1'b0;
      cfg_never = 1'b0;
      cfg_a     = a;
      cfg_d     = d;
      cfg_h     = h;
   endtask

   task automatic check_reset_outputs();
      check_value("rst_req_ready",   32'(req_ready),   32'(0));
      check_value("rst_tx_send",     32'(tx_send),     32'(0));
      check_value("rst_tx_data",     32'(tx_data),     32'(0));
      check_value("rst_grant_id",    32'(grant_id),    32'(0));
      check_value("rst_busy",        32'(busy),        32'(0));
      check_value("rst_err_timeout", 32'(err_timeout), 32'(0));
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) cur_byte[i] = 8'h00;
      #1 reset = 1'b0;
      #1 check_reset_outputs();
      repeat (2) @(posedge sys_clk);
      #3 reset = 1'b1;

      // Single request from requester 1
      set_fixed(3, 13, 1);
      req_mode = 0;
      cur_valid = 4'b0010;
      cur_byte[1] = 8'h37;
      drive_inputs();
      run_cycles(20);

      // All four continuously valid
      req_mode = 2;
      set_fixed(2, 6, 1);
      for (int i = 0; i < NUM_REQ; i++) cur_byte[i] = 8'hA0 + 8'(i);
      cur_valid = 4'b1111;
      drive_inputs();
      run_cycles(45);

      // Fairness between 0 and 2, then requester 1 joins mid-frame
      cur_valid = 4'b0101;
      drive_inputs();
      run_cycles(30);
      cur_valid[1] = 1'b1;
      drive_inputs();
      run_cycles(30);

      // Level-held done
      set_fixed(3, 8, 5);
      run_cycles(60);

      // Random traffic with random frame timelines
      cfg_rand = 1'b1;
      req_mode = 1;
      run_cycles(1500);
      req_mode = 0;
      run_cycles(200);

      // Done arriving on the same edge the watchdog would expire
      set_fixed(3, TIMEOUT, 2);
      cur_valid = 4'b0001;
      cur_byte[0] = 8'h5C;
      drive_inputs();
      run_cycles(60);

      // Transmitter never responds, then a later request is still served
      cfg_never = 1'b1;
      cur_valid = 4'b0100;
      cur_byte[2] = 8'h99;
      drive_inputs();
      run_cycles(TIMEOUT + 5);
      set_fixed(2, 5, 1);
      cur_valid = 4'b1000;
      cur_byte[3] = 8'hE7;
      drive_inputs();
      run_cycles(15);

      // Asynchronous reset while waiting for done
      set_fixed(3, 13, 1);
      cur_valid = 4'b0010;
      cur_byte[1] = 8'h6B;
      drive_inputs();
      run_cycles(8);
      #2 reset = 1'b0;
      cur_valid = '0;
      f_on = 1'b0;
      drive_inputs();
      #1 check_reset_outputs();
      m_last = NUM_REQ - 1;
      m_id   = 0;
      m_data = 8'h00;
      m_err  = 1'b0;
      repeat (2) @(posedge sys_clk);
      #3 reset = 1'b1;

      // After reset requester 0 wins first: order 0,1,2,3,0
      req_mode = 2;
      set_fixed(2, 5, 2);
      for (int i = 0; i < NUM_REQ; i++) cur_byte[i] = 8'hA0 + 8'(i);
      cur_valid = 4'b1111;
      drive_inputs();
      run_cycles(45);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
